bin2bcd_converter: RTL

Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3). It sits directly upstream of the seven-segment display decoder. It turns a switch- or datapath-supplied binary word into per-digit BCD codes and a sign flag, which the decoder then multiplexes onto the cathodes. One conversion runs per `start`, one shift per clock, and results stay stable between conversions.

---
 rtl/bin2bcd_converter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bin2bcd_converter.sv
// bin2bcd_converter: sequential binary-to-BCD converter (iterative double-dabble,
// one shift per clock). Produces DIGITS packed BCD digits plus a sign flag for a
// downstream seven-segment decoder.
//
// Parameters:
//   WIDTH  - binary input width (>= 2)
//   DIGITS - BCD digits produced; 10**DIGITS must exceed 2**WIDTH
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   bin_in       - value to convert, sampled when start is accepted
//   signed_mode  - 1: bin_in is two's complement, 0: unsigned
//   start        - conversion request, accepted in IDLE or DONE
//   busy         - high while shifting
//   done         - one-cycle pulse when bcd_out/negative are updated
//   negative     - sign of the last completed conversion
//   bcd_out      - digit k in bits [4k+3:4k], k=0 least significant
// Build option:
//   BIN2BCD_BLANK_EN - when defined, leading zero digits (except digit 0) are
//                      replaced by 4'hF when a result is loaded.
module bin2bcd_converter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  signed_mode,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_r_q, neg_r_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               negative_q, negative_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic [BCD_W-1:0]   bcd_final;
  logic               in_neg;

  // Add-3 correction per digit before the shift (no carry between digits)
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Scratch value after this cycle's shift; on the last shift it is the result
  assign shifted = {adj[BCD_W-2:0], mag_q[WIDTH-1]};

`ifdef BIN2BCD_BLANK_EN
  // Blank leading zeros from the top digit down, stopping at the first nonzero;
  // digit 0 always shows
  logic lead;
  always_comb begin
    bcd_final = shifted;
    lead      = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (lead && (shifted[4*k +: 4] == 4'd0)) begin
        bcd_final[4*k +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign bcd_final = shifted;
`endif

  assign in_neg = signed_mode & bin_in[WIDTH-1];

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    scratch_d  = scratch_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    neg_r_d    = neg_r_q;
    negative_d = negative_q;
    bcd_d      = bcd_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          neg_r_d   = in_neg;
          // Two's-complement negate; the most negative input maps to 2**(WIDTH-1)
          mag_d     = in_neg ? (~bin_in + WIDTH'(1)) : bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = ST_SHIFT;
          busy_d    = 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        scratch_d = shifted;
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        busy_d    = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          bcd_d      = bcd_final;
          negative_d = neg_r_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      scratch_q  <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      neg_r_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      negative_q <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      scratch_q  <= scratch_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      neg_r_q    <= neg_r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      negative_q <= negative_d;
      bcd_q      <= bcd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign negative = negative_q;
  assign bcd_out  = bcd_q;

endmodule
